// File: rtl/piso_pkg.sv
// piso_pkg: shared types, constants and counter sizing for the PISO serializer.
// PISO_PARITY_EN selects the optional trailing even-parity bit.
package piso_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam int PISO_DEFAULT_WIDTH = 8;

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // The parity slot needs one extra count value beyond the data bits.
    function automatic int cnt_width(input int width, input bit parity);
        return $clog2(width) + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake, bit-rate strobe and serial output of the PISO serializer.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_ena;
    logic             serial_data;
    logic             data_ena;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, shift_ena,
        input  load_ready, serial_data, data_ena, busy, done
    );

    modport slave (
        input  load_valid, load_data, shift_ena,
        output load_ready, serial_data, data_ena, busy, done
    );

endinterface

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: modulo-MOD counter with enable, synchronous clear and terminal-count flag.
module piso_bit_cnt #(
    parameter int W   = 3,
    parameter int MOD = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = cnt_q == W'(MOD - 1);

    always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + W'(1)) : cnt_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter paced by shift_ena, feeding a SIPO receiver.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    piso_serializer_if.slave bus
);

    localparam int            IW       = $clog2(WIDTH);
    localparam int            CW       = cnt_width(WIDTH, PARITY_EN);
    localparam int            FRAME    = WIDTH + int'(PARITY_EN);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [0:0]    ST_IDLE  = IDLE;
    localparam logic [0:0]    ST_SHIFT = SHIFT;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             serial_q, serial_d;
    logic             ena_q, ena_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic             last, accept, shift, data_bit, next_bit;

    assign accept   = state_q == ST_IDLE && bus.load_valid;
    assign shift    = state_q == ST_SHIFT && bus.shift_ena;
    assign idx      = cnt[IW-1:0];
    assign data_bit = shadow_q[LSB_FIRST ? idx : LAST_IDX - idx];

`ifdef PISO_PARITY_EN
    assign next_bit = (cnt == CW'(WIDTH)) ? ^shadow_q : data_bit;
`else
    assign next_bit = data_bit;
`endif

    piso_bit_cnt #(.W(CW), .MOD(FRAME)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (shift),
        .cnt     (cnt),
        .tc      (last)
    );

    always_comb begin
        state_d  = accept ? ST_SHIFT : (shift && last) ? ST_IDLE : state_q;
        shadow_d = accept ? bus.load_data : shadow_q;
        serial_d = shift ? next_bit : serial_q;
        ena_d    = shift;
        done_d   = shift && last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            serial_q <= 1'b0;
            ena_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            serial_q <= serial_d;
            ena_q    <= ena_d;
            done_q   <= done_d;
        end
    end

    assign bus.load_ready  = state_q == ST_IDLE;
    assign bus.busy        = state_q == ST_SHIFT;
    assign bus.serial_data = serial_q;
    assign bus.data_ena    = ena_q;
    assign bus.done        = done_q;

endmodule
